// File: rtl/otter_pkg.sv
// otter_pkg: shared control-transfer types and link-register indices
package otter_pkg;
  typedef enum logic [1:0] {BR_NONE = 2'd0, BR_COND = 2'd1, BR_JAL = 2'd2, BR_JALR = 2'd3} branch_op_t;
  localparam logic [4:0] LINK_X1 = 5'd1;
  localparam logic [4:0] LINK_X5 = 5'd5;
endpackage

// File: rtl/ras_stack.sv
// ras_stack: circular return-address stack with saturating count
module ras_stack #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic            pop,
  input  logic [XLEN-1:0] push_data,
  output logic [XLEN-1:0] top_data,
  output logic            empty
);
  localparam int AW = $clog2(DEPTH);
  logic [XLEN-1:0] mem [DEPTH];
  logic [AW-1:0] top;
  logic [AW:0] cnt;
  logic full;
  assign empty = cnt == '0;
  assign full = cnt == (AW+1)'(DEPTH);
  assign top_data = mem[top];
  // a full push advances onto the oldest slot, so the count simply saturates
  always_ff @(posedge clk) begin
    if (rst) begin
      top <= '0;
      cnt <= '0;
    end else if (push && pop && !empty) begin
      mem[top] <= push_data;
    end else if (push) begin
      top <= top + 1'b1;
      mem[top + 1'b1] <= push_data;
      cnt <= full ? cnt : cnt + 1'b1;
    end else if (pop && !empty) begin
      top <= top - 1'b1;
      cnt <= cnt - 1'b1;
    end
  end
endmodule

// File: rtl/branch_target_unit.sv
// branch_target_unit: branch/jump target, alignment check and RAS prediction, one register stage
module branch_target_unit
  import otter_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int RAS_DEPTH = 4,
  parameter int C_EXT     = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_in,
  input  logic            flush,
  input  branch_op_t      op,
  input  logic            br_taken,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] imm,
  input  logic [4:0]      rd_addr,
  input  logic [4:0]      rs1_addr,
  output logic            valid_out,
  output logic [XLEN-1:0] target,
  output logic [XLEN-1:0] link,
  output logic            redirect,
  output logic            misalign,
  output logic [XLEN-1:0] ras_pred,
  output logic            ras_hit,
  output logic            ras_empty
);
  logic act, taken, mis, rd_lnk, rs_lnk, push, pop, st_empty;
  logic [XLEN-1:0] sum, tgt, nxt_link, top_data;
  always_comb begin
    act = valid_in && !flush && op != BR_NONE;
    sum = (op == BR_JALR ? rs1 : pc) + imm;
    tgt = op == BR_JALR ? {sum[XLEN-1:1], 1'b0} : sum;
    nxt_link = pc + XLEN'(4);
    taken = op == BR_JAL || op == BR_JALR || (op == BR_COND && br_taken);
    mis = C_EXT != 0 ? tgt[0] : |tgt[1:0];
    rd_lnk = rd_addr == LINK_X1 || rd_addr == LINK_X5;
    rs_lnk = rs1_addr == LINK_X1 || rs1_addr == LINK_X5;
    push = act && (op == BR_JAL || op == BR_JALR) && rd_lnk;
    pop = act && op == BR_JALR && rs_lnk && !(rd_lnk && rd_addr == rs1_addr);
  end
  ras_stack #(.XLEN(XLEN), .DEPTH(RAS_DEPTH)) u_ras (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .push_data(nxt_link),
    .top_data(top_data), .empty(st_empty)
  );
  assign ras_empty = st_empty;
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_out <= 1'b0;
      target <= '0;
      link <= '0;
      redirect <= 1'b0;
      misalign <= 1'b0;
      ras_pred <= '0;
      ras_hit <= 1'b0;
    end else begin
      valid_out <= act;
      target <= act ? (taken ? tgt : nxt_link) : '0;
      link <= act ? nxt_link : '0;
      redirect <= act && taken && !mis;
      misalign <= act && taken && mis;
      ras_pred <= pop && !st_empty ? top_data : '0;
      ras_hit <= pop && !st_empty && top_data == tgt;
    end
  end
endmodule

// File: tb/tb_branch_target_unit.sv
// tb_branch_target_unit: directed scoreboard bench over 4-byte and 2-byte alignment variants
module tb_branch_target_unit;
  import otter_pkg::*;
  typedef struct {
    logic v;
    logic [31:0] t, l;
    logic r0, m0, r1, m1;
    logic [31:0] p;
    logic h, e;
  } exp_t;
  logic clk = 1'b0, rst = 1'b1, valid_in = 1'b0, flush = 1'b0, br_taken = 1'b0;
  branch_op_t op = BR_NONE;
  logic [31:0] pc = '0, rs1 = '0, imm = '0;
  logic [4:0] rd_addr = '0, rs1_addr = '0;
  logic v0, r0, m0, h0, e0, v1, r1, m1, h1, e1;
  logic [31:0] t0, l0, p0, t1, l1, p1;
  exp_t q[$];
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  branch_target_unit #(.XLEN(32), .RAS_DEPTH(4), .C_EXT(0)) d0 (
    .clk(clk), .rst(rst), .valid_in(valid_in), .flush(flush), .op(op), .br_taken(br_taken),
    .pc(pc), .rs1(rs1), .imm(imm), .rd_addr(rd_addr), .rs1_addr(rs1_addr),
    .valid_out(v0), .target(t0), .link(l0), .redirect(r0), .misalign(m0),
    .ras_pred(p0), .ras_hit(h0), .ras_empty(e0)
  );
  branch_target_unit #(.XLEN(32), .RAS_DEPTH(4), .C_EXT(1)) d1 (
    .clk(clk), .rst(rst), .valid_in(valid_in), .flush(flush), .op(op), .br_taken(br_taken),
    .pc(pc), .rs1(rs1), .imm(imm), .rd_addr(rd_addr), .rs1_addr(rs1_addr),
    .valid_out(v1), .target(t1), .link(l1), .redirect(r1), .misalign(m1),
    .ras_pred(p1), .ras_hit(h1), .ras_empty(e1)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask
  task automatic check_out();
    exp_t x;
    checks++;
    assert (q.size() > 0) else begin
      errors++;
      $error("FAIL scoreboard: observed empty queue expected an entry");
      return;
    end
    x = q.pop_front();
    chk("c0.valid", {31'd0, v0}, {31'd0, x.v});
    chk("c0.target", t0, x.t);
    chk("c0.link", l0, x.l);
    chk("c0.redirect", {31'd0, r0}, {31'd0, x.r0});
    chk("c0.misalign", {31'd0, m0}, {31'd0, x.m0});
    chk("c0.ras_pred", p0, x.p);
    chk("c0.ras_hit", {31'd0, h0}, {31'd0, x.h});
    chk("c0.ras_empty", {31'd0, e0}, {31'd0, x.e});
    chk("c1.valid", {31'd0, v1}, {31'd0, x.v});
    chk("c1.target", t1, x.t);
    chk("c1.link", l1, x.l);
    chk("c1.redirect", {31'd0, r1}, {31'd0, x.r1});
    chk("c1.misalign", {31'd0, m1}, {31'd0, x.m1});
    chk("c1.ras_pred", p1, x.p);
    chk("c1.ras_hit", {31'd0, h1}, {31'd0, x.h});
    chk("c1.ras_empty", {31'd0, e1}, {31'd0, x.e});
  endtask
  task automatic step(input branch_op_t o, input logic tk, input logic [31:0] a_pc, a_rs1, a_imm,
                      input logic [4:0] rd, rs, input logic fl, input exp_t x);
    valid_in = 1'b1;
    op = o;
    br_taken = tk;
    pc = a_pc;
    rs1 = a_rs1;
    imm = a_imm;
    rd_addr = rd;
    rs1_addr = rs;
    flush = fl;
    q.push_back(x);
    @(posedge clk);
    #1 check_out();
    valid_in = 1'b0;
    flush = 1'b0;
  endtask
  function automatic exp_t ex(input logic v, input logic [31:0] t, l, input logic r0_, m0_, r1_, m1_,
                              input logic [31:0] p, input logic h, e);
    exp_t x;
    x.v = v; x.t = t; x.l = l; x.r0 = r0_; x.m0 = m0_; x.r1 = r1_; x.m1 = m1_;
    x.p = p; x.h = h; x.e = e;
    return x;
  endfunction
  task automatic check_reset(input string tag);
    chk({tag, ".c0.valid"}, {31'd0, v0}, 32'd0);
    chk({tag, ".c0.target"}, t0, 32'd0);
    chk({tag, ".c0.link"}, l0, 32'd0);
    chk({tag, ".c0.flags"}, {28'd0, r0, m0, h0, 1'b0}, 32'd0);
    chk({tag, ".c0.ras_pred"}, p0, 32'd0);
    chk({tag, ".c0.ras_empty"}, {31'd0, e0}, 32'd1);
    chk({tag, ".c1.valid"}, {31'd0, v1}, 32'd0);
    chk({tag, ".c1.target"}, t1, 32'd0);
    chk({tag, ".c1.flags"}, {28'd0, r1, m1, h1, 1'b0}, 32'd0);
    chk({tag, ".c1.ras_empty"}, {31'd0, e1}, 32'd1);
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1 check_reset("init");
    rst = 1'b0;
    step(BR_JAL, 0, 32'h40, 0, 32'h100, 5'd1, 5'd0, 0, ex(1, 32'h140, 32'h44, 1, 0, 1, 0, 0, 0, 0));
    rst = 1'b1;
    valid_in = 1'b1;
    op = BR_JAL;
    rd_addr = 5'd1;
    repeat (2) @(posedge clk);
    #1 check_reset("reset");
    rst = 1'b0;
    valid_in = 1'b0;
    step(BR_COND, 1, 32'h100, 0, 32'hFFFFFFF0, 5'd0, 5'd0, 0, ex(1, 32'hF0, 32'h104, 1, 0, 1, 0, 0, 0, 1));
    step(BR_COND, 0, 32'h100, 0, 32'hFFFFFFF0, 5'd0, 5'd0, 0, ex(1, 32'h104, 32'h104, 0, 0, 0, 0, 0, 0, 1));
    step(BR_JALR, 0, 32'h200, 32'h2003, 0, 5'd0, 5'd2, 0, ex(1, 32'h2002, 32'h204, 0, 1, 1, 0, 0, 0, 1));
    step(BR_JAL, 0, 32'h40, 0, 32'h100, 5'd1, 5'd0, 0, ex(1, 32'h140, 32'h44, 1, 0, 1, 0, 0, 0, 0));
    step(BR_JALR, 0, 32'h140, 32'h44, 0, 5'd0, 5'd1, 0, ex(1, 32'h44, 32'h144, 1, 0, 1, 0, 32'h44, 1, 1));
    step(BR_JAL, 0, 32'h40, 0, 32'h100, 5'd1, 5'd0, 1, ex(0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    step(BR_NONE, 0, 32'h40, 0, 32'h100, 5'd1, 5'd0, 0, ex(0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    step(BR_JAL, 0, 32'hFFFFFFFC, 0, 32'h8, 5'd0, 5'd0, 0, ex(1, 32'h4, 32'h0, 1, 0, 1, 0, 0, 0, 1));
    for (int i = 0; i < 5; i++)
      step(BR_JAL, 0, 32'(4 * i), 0, 32'h100, 5'd1, 5'd0, 0,
           ex(1, 32'(32'h100 + 4 * i), 32'(4 * i + 4), 1, 0, 1, 0, 0, 0, 0));
    for (int i = 0; i < 4; i++)
      step(BR_JALR, 0, 32'h300, 32'(32'h14 - 4 * i), 0, 5'd0, 5'd1, 0,
           ex(1, 32'(32'h14 - 4 * i), 32'h304, 1, 0, 1, 0, 32'(32'h14 - 4 * i), 1, i == 3));
    step(BR_JALR, 0, 32'h300, 32'h4, 0, 5'd0, 5'd1, 0, ex(1, 32'h4, 32'h304, 1, 0, 1, 0, 0, 0, 1));
    step(BR_JAL, 0, 32'h500, 0, 32'h100, 5'd5, 5'd0, 0, ex(1, 32'h600, 32'h504, 1, 0, 1, 0, 0, 0, 0));
    step(BR_JALR, 0, 32'h600, 32'h504, 0, 5'd1, 5'd5, 0, ex(1, 32'h504, 32'h604, 1, 0, 1, 0, 32'h504, 1, 0));
    step(BR_JALR, 0, 32'h700, 32'h604, 0, 5'd0, 5'd1, 0, ex(1, 32'h604, 32'h704, 1, 0, 1, 0, 32'h604, 1, 1));
    step(BR_JALR, 0, 32'h800, 32'h900, 0, 5'd1, 5'd1, 0, ex(1, 32'h900, 32'h804, 1, 0, 1, 0, 0, 0, 0));
    chk("q_drained", 32'(q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
